bp_btb: RTL and testbench
=========================

Name: bp_btb

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters. It generalises the fetch-side prediction fields (predict_taken / predict_pc) into a configurable, direct-mapped predictor.
- Sits beside the IF stage. It gives a same-cycle combinational prediction for the fetch PC and is trained by the resolved-branch update from EX.
- An optional return address stack improves JALR prediction.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- CNT_W, 2, direction counter width, at least 1.
- RAS_DEPTH, 4, return address stack entries (used only with BP_RAS_EN); power of two.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- lookup_pc  in  XLEN  fetch PC
- hit  out  1  valid tag match for lookup_pc
- predict_taken  out  1  predicted redirect
- predict_pc  out  XLEN  predicted next PC
- upd_valid  in  1  resolved control-flow instruction from EX this cycle
- upd_pc  in  XLEN  PC of resolved instruction
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  resolved direction
- upd_is_cond  in  1  conditional branch
- upd_is_jal  in  1  JAL
- upd_is_jalr  in  1  JALR
- upd_is_call  in  1  call, meaning JAL/JALR with rd=x1/x5 (RAS only)
- upd_is_ret  in  1  return, meaning JALR rs1=x1/x5, rd=x0 (RAS only)
- flush  in  1  invalidate all entries

Behaviour:
- Fields:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - Each entry holds: valid, tag, target[XLEN], type{COND,JAL,JALR}, cnt[CNT_W].
- Reset (async, rst=1):
  - All valid=0 and all cnt=weakly-not-taken (2^(CNT_W-1)-1).
  - RAS count=0 and pointer=0.
  - Outputs therefore read hit=0, predict_taken=0, predict_pc=lookup_pc+4.
- Lookup (combinational, 0-cycle latency):
  - hit = valid[index] && tag match.
  - predict_taken = hit && (type==COND ? cnt MSB : 1).
  - predict_pc = predict_taken ? target : lookup_pc+4, with +4 wrapping modulo 2^XLEN.
- Update (registered, visible the cycle after upd_valid):
  - Applies only when upd_valid and exactly one of is_cond/is_jal/is_jalr is set. Otherwise the update is ignored with no state change.
  - Tag hit: cnt +1 if upd_taken, else -1. The counter saturates at 2^CNT_W-1 and at 0. If upd_taken, target and type are rewritten.
  - Tag miss or invalid: allocate only if upd_taken. Allocation writes valid=1, tag, target, type, and cnt=weakly-taken (2^(CNT_W-1)). A not-taken miss changes nothing.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. There is no bypass.
- flush:
  - Clears all valid bits at the next edge. Counters are kept.
  - If flush and upd_valid occur in the same cycle, flush wins and no allocation happens.
- Reset asserted mid-operation aborts any pending write. The state is exactly the reset state.

Optional Feature:
- Macro BP_RAS_EN.
- When defined, a circular RAS of RAS_DEPTH entries is instantiated.
  - On an update with upd_is_call, it pushes upd_pc+4.
  - On upd_is_ret, it pops.
  - When both are set, it pops and then pushes, which replaces the top.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty is ignored.
  - On a lookup hit with type==JALR and RAS non-empty, predict_pc = RAS top instead of the BTB target.
  - flush does not clear the RAS.
- When undefined, there is no RAS logic, upd_is_call and upd_is_ret are ignored, and JALR uses the BTB target.

Test Plan:
- Reset, then lookup_pc=0x100 -> hit=0, predict_taken=0, predict_pc=0x104.
- Update pc=0x100, cond, taken, target=0x80; next cycle lookup 0x100 -> hit=1, predict_taken=1, predict_pc=0x80. Two not-taken updates -> predict_taken=0, predict_pc=0x104. Four taken updates -> counter saturates at 3; one not-taken update still predicts taken.
- Update pc=0x100 taken, then update pc=0x140 (same index, ENTRIES=16) JAL taken target=0x200 -> lookup 0x100 hit=0; lookup 0x140 predict_pc=0x200.
- Not-taken cond update at empty pc=0x300 -> lookup 0x300 hit=0. Same-cycle lookup and allocating update of 0x300 -> that cycle hit=0, next cycle hit=1.
- Fill entries, assert flush together with a taken update -> all lookups hit=0, no allocation.
- BP_RAS_EN: call at pc=0x1000, then JALR entry at 0x2000 with BTB target 0x9999 -> lookup 0x2000 predict_pc=0x1004. Five calls with RAS_DEPTH=4, then five returns -> the last pop is ignored and the predictions fall back to the BTB target.

Source files
------------

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Define BP_RAS_EN to add a return address stack for JALR prediction.
module bp_btb #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_is_cond,
    input  logic            upd_is_jal,
    input  logic            upd_is_jalr,
    input  logic            upd_is_call,
    input  logic            upd_is_ret,
    input  logic            flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] T_COND = 2'd0;
    localparam logic [1:0] T_JAL  = 2'd1;
    localparam logic [1:0] T_JALR = 2'd2;

    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         type_q   [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_legal;
    logic             upd_ok;
    logic             upd_hit;
    logic [1:0]       upd_type;
    logic             entry_we;
    logic             tgt_we;
    logic [CNT_W-1:0] cnt_d;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  tgt_pc;
    logic             ras_use;
    logic [XLEN-1:0]  ras_top;

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Exactly one control-flow kind must be flagged for a legal update
    always_comb begin
        upd_idx   = upd_pc[IDX_W+1:2];
        upd_tag   = upd_pc[XLEN-1:IDX_W+2];
        upd_legal = upd_valid &&
                    ((upd_is_cond && !upd_is_jal && !upd_is_jalr) ||
                     (!upd_is_cond && upd_is_jal && !upd_is_jalr) ||
                     (!upd_is_cond && !upd_is_jal && upd_is_jalr));
        upd_ok    = upd_legal && !flush;
        upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_type  = upd_is_cond ? T_COND : (upd_is_jal ? T_JAL : T_JALR);
        entry_we  = upd_ok && (upd_hit || upd_taken);
        tgt_we    = upd_ok && upd_taken;
        cnt_d     = CNT_WT;
        if (upd_hit) begin
            if (upd_taken) begin
                cnt_d = (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX
                        : cnt_q[upd_idx] + 1'b1;
            end else begin
                cnt_d = (cnt_q[upd_idx] == '0) ? '0
                        : cnt_q[upd_idx] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                type_q[i]   <= T_COND;
                cnt_q[i]    <= CNT_WNT;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (entry_we) begin
                cnt_q[upd_idx] <= cnt_d;
            end
            if (tgt_we) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                type_q[upd_idx]   <= upd_type;
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int RAS_W = $clog2(RAS_DEPTH);

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [RAS_W-1:0] ras_ptr_q;
    logic [RAS_W-1:0] ras_ptr_d;
    logic [RAS_W:0]   ras_cnt_q;
    logic [RAS_W:0]   ras_cnt_d;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_we;
    logic [RAS_W-1:0] ras_slot;
    logic [XLEN-1:0]  ras_val;

    // ras_ptr_q addresses the next free slot; the top sits just below it
    always_comb begin
        ras_push  = upd_legal && upd_is_call;
        ras_pop   = upd_legal && upd_is_ret && (ras_cnt_q != '0);
        ras_val   = upd_pc + XLEN'(4);
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_slot  = ras_ptr_q;
        if (ras_push && ras_pop) begin
            ras_we   = 1'b1;
            ras_slot = ras_ptr_q - 1'b1;
        end else if (ras_push) begin
            ras_we    = 1'b1;
            ras_ptr_d = ras_ptr_q + 1'b1;
            if (ras_cnt_q != (RAS_W+1)'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + 1'b1;
            end
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - 1'b1;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_we) begin
                ras_q[ras_slot] <= ras_val;
            end
        end
    end

    assign ras_top = ras_q[ras_ptr_q - 1'b1];
    assign ras_use = (type_q[lk_idx] == T_JALR) && (ras_cnt_q != '0);
`else
    logic unused_ras;
    assign unused_ras = ^{upd_is_call, upd_is_ret};
    assign ras_top    = '0;
    assign ras_use    = 1'b0;
`endif

    always_comb begin
        lk_idx        = lookup_pc[IDX_W+1:2];
        lk_tag        = lookup_pc[XLEN-1:IDX_W+2];
        hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        predict_taken = hit && ((type_q[lk_idx] == T_COND)
                        ? cnt_q[lk_idx][CNT_W-1] : 1'b1);
        seq_pc        = lookup_pc + XLEN'(4);
        tgt_pc        = ras_use ? ras_top : target_q[lk_idx];
        predict_pc    = predict_taken ? tgt_pc : seq_pc;
    end

endmodule

// File: tb/tb_bp_btb.sv
// Randomised bench for bp_btb checked against a table-level predictor model.
// Build with BP_RAS_EN defined to also exercise the return address stack.
module tb_bp_btb;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int DEPTH   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] lookup_pc = '0;
    logic            hit;
    logic            predict_taken;
    logic [XLEN-1:0] predict_pc;
    logic            upd_valid = 1'b0;
    logic [XLEN-1:0] upd_pc = '0;
    logic [XLEN-1:0] upd_target = '0;
    logic            upd_taken = 1'b0;
    logic            upd_is_cond = 1'b0;
    logic            upd_is_jal = 1'b0;
    logic            upd_is_jalr = 1'b0;
    logic            upd_is_call = 1'b0;
    logic            upd_is_ret = 1'b0;
    logic            flush = 1'b0;

    int checks = 0;
    int errors = 0;

    bp_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(2), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .hit(hit),
        .predict_taken(predict_taken), .predict_pc(predict_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_is_cond(upd_is_cond),
        .upd_is_jal(upd_is_jal), .upd_is_jalr(upd_is_jalr),
        .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret), .flush(flush)
    );

    always #5 clk = ~clk;

    // Model: a table indexed by pc/4 mod ENTRIES, kinds 0=cond 1=jal 2=jalr
    bit          m_valid [ENTRIES] = '{default: 1'b0};
    int unsigned m_tag   [ENTRIES] = '{default: 0};
    logic [31:0] m_tgt   [ENTRIES] = '{default: 32'h0};
    int          m_kind  [ENTRIES] = '{default: 0};
    int          m_cnt   [ENTRIES] = '{default: 1};
    logic [31:0] m_ras [$];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_ras.delete();
    endtask

    task automatic model_expect(input logic [31:0] pc, output logic h,
                                output logic t, output logic [31:0] npc);
        int i;
        i   = idx_of(pc);
        h   = m_valid[i] && (m_tag[i] == tag_of(pc));
        t   = h && ((m_kind[i] == 0) ? (m_cnt[i] >= 2) : 1'b1);
        npc = pc + 32'd4;
        if (t) begin
            npc = m_tgt[i];
`ifdef BP_RAS_EN
            if (m_kind[i] == 2 && m_ras.size() > 0) npc = m_ras[$];
`endif
        end
    endtask

    task automatic model_update();
        int i;
        int kinds;
        bit legal;
        bit mhit;
        i     = idx_of(upd_pc);
        kinds = int'(upd_is_cond) + int'(upd_is_jal) + int'(upd_is_jalr);
        legal = upd_valid && (kinds == 1);
        mhit  = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
        if (flush) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
        end else if (legal) begin
            if (mhit) m_cnt[i] = upd_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                           : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
            else if (upd_taken) m_cnt[i] = 2;
            if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target;
                m_kind[i]  = upd_is_cond ? 0 : (upd_is_jal ? 1 : 2);
            end
        end
`ifdef BP_RAS_EN
        if (legal) begin
            if (upd_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
            if (upd_is_call) begin
                m_ras.push_back(upd_pc + 32'd4);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
        end
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_update();
        end
    end

    initial begin
        logic        eh;
        logic        et;
        logic [31:0] ep;
        forever begin
            @(negedge clk);
            model_expect(lookup_pc, eh, et, ep);
            chk("model_hit", {31'b0, hit}, {31'b0, eh});
            chk("model_taken", {31'b0, predict_taken}, {31'b0, et});
            chk("model_pc", predict_pc, ep);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        upd_valid   = 1'b0;
        upd_is_cond = 1'b0;
        upd_is_jal  = 1'b0;
        upd_is_jalr = 1'b0;
        upd_is_call = 1'b0;
        upd_is_ret  = 1'b0;
        upd_taken   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt,
                           input bit tk, input int kind,
                           input bit call = 1'b0, input bit ret = 1'b0);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_target  = tgt;
        upd_taken   = tk;
        upd_is_cond = (kind == 0);
        upd_is_jal  = (kind == 1);
        upd_is_jalr = (kind == 2);
        upd_is_call = call;
        upd_is_ret  = ret;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input bit tk, input int kind,
                       input bit call = 1'b0, input bit ret = 1'b0);
        set_upd(pc, tgt, tk, kind, call, ret);
        cyc();
        clr();
    endtask

    task automatic look(input string nm, input logic [31:0] pc,
                        input bit eh, input bit et, input logic [31:0] ep);
        lookup_pc = pc;
        @(negedge clk);
        chk({nm, "_hit"}, {31'b0, hit}, {31'b0, eh});
        chk({nm, "_taken"}, {31'b0, predict_taken}, {31'b0, et});
        chk({nm, "_pc"}, predict_pc, ep);
        cyc();
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return {$urandom()} & 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        int k;
        cyc();
        cyc();
        look("reset", 32'h100, 0, 0, 32'h104);
        rst = 1'b0;
        cyc();

        look("empty", 32'h100, 0, 0, 32'h104);
        look("wrap", 32'hFFFF_FFFC, 0, 0, 32'h0);
        upd(32'h100, 32'h80, 1, 0);
        look("alloc", 32'h100, 1, 1, 32'h80);
        upd(32'h100, 32'h80, 0, 0);
        upd(32'h100, 32'h80, 0, 0);
        look("nt2", 32'h100, 1, 0, 32'h104);
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h80, 1, 0);
        upd(32'h100, 32'h80, 0, 0);
        look("sat", 32'h100, 1, 1, 32'h80);

        upd(32'h140, 32'h200, 1, 1);
        look("alias_old", 32'h100, 0, 0, 32'h104);
        look("alias_new", 32'h140, 1, 1, 32'h200);

        upd(32'h304, 32'h44, 0, 0);
        look("nt_miss", 32'h304, 0, 0, 32'h308);
        lookup_pc = 32'h304;
        set_upd(32'h304, 32'h44, 1, 0);
        @(negedge clk);
        chk("no_bypass_hit", {31'b0, hit}, 32'd0);
        cyc();
        clr();
        look("after_alloc", 32'h304, 1, 1, 32'h44);

        set_upd(32'h608, 32'h70, 1, 0);
        upd_is_jal = 1'b1;
        cyc();
        clr();
        look("illegal", 32'h608, 0, 0, 32'h60C);

        for (int i = 0; i < 8; i++) upd(32'h400 + 32'(4 * i), 32'h900 + 32'(i), 1, 1);
        look("filled", 32'h40C, 1, 1, 32'h903);
        set_upd(32'h420, 32'hA00, 1, 2);
        flush = 1'b1;
        cyc();
        clr();
        for (int i = 0; i < 8; i++) look("flushed", 32'h400 + 32'(4 * i), 0, 0,
                                        32'h404 + 32'(4 * i));
        look("flush_noalloc", 32'h420, 0, 0, 32'h424);

        upd(32'h500, 32'h600, 1, 1);
        rst = 1'b1;
        set_upd(32'h504, 32'h700, 1, 1);
        cyc();
        clr();
        rst = 1'b0;
        look("midreset_a", 32'h500, 0, 0, 32'h504);
        look("midreset_b", 32'h504, 0, 0, 32'h508);

`ifdef BP_RAS_EN
        upd(32'h1000, 32'h5000, 1, 1, 1, 0);
        upd(32'h2008, 32'h9999, 1, 2);
        look("ras_top", 32'h2008, 1, 1, 32'h1004);
        for (int i = 0; i < 5; i++) upd(32'h1000 + 32'(64 * i), 32'h5000, 1, 1, 1, 0);
        look("ras_full", 32'h2008, 1, 1, 32'h1104);
        for (int i = 0; i < 4; i++) upd(32'h3004, 32'h7000, 1, 2, 0, 1);
        look("ras_empty", 32'h2008, 1, 1, 32'h9999);
        upd(32'h3004, 32'h7000, 1, 2, 0, 1);
        look("ras_underflow", 32'h2008, 1, 1, 32'h9999);
`endif

        for (int n = 0; n < 1500; n++) begin
            lookup_pc = rand_pc();
            clr();
            upd_valid  = ($urandom_range(0, 3) != 0);
            upd_pc     = rand_pc();
            upd_target = {$urandom()};
            upd_taken  = ($urandom_range(0, 2) != 0);
            k = int'($urandom_range(0, 7));
            upd_is_cond = (k <= 2) || (k == 6);
            upd_is_jal  = (k == 3) || (k == 4) || (k == 6);
            upd_is_jalr = (k == 5);
            upd_is_call = ($urandom_range(0, 3) == 0);
            upd_is_ret  = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        clr();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
